// File: rtl/f_select_ctrl.sv
// f_select_ctrl
// Sequences the frequency-select ROM and runs the half-period counter of the
// frequency divider. A select request is clamped to the populated ROM range.
// It is fetched through the ROM's one-cycle registered read, then applied.
// A running divider only takes a new half-period at a terminal count, so
// clk_out never has a short or stretched half-cycle.
module f_select_ctrl #(
    parameter int WIDTH_DIR  = 5,
    parameter int WIDTH_DATA = 28,
    parameter int MAX_SEL    = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_valid,
    input  logic [WIDTH_DIR-1:0]  sel,
    output logic                  sel_ready,
    output logic [WIDTH_DIR-1:0]  rom_dir,
    input  logic [WIDTH_DATA-1:0] rom_data,
    output logic                  clk_out,
    output logic                  tick,
    output logic [WIDTH_DIR-1:0]  cur_sel,
    output logic                  sel_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAT,
        S_CAP,
        S_PEND
    } state_t;

    localparam logic [WIDTH_DIR-1:0]  MAX_DIR  = WIDTH_DIR'(MAX_SEL);
    localparam logic [WIDTH_DATA-1:0] ONE_DATA = WIDTH_DATA'(1);

    state_t                state;
    logic [WIDTH_DATA-1:0] cnt;
    logic [WIDTH_DATA-1:0] period;
    logic [WIDTH_DATA-1:0] next_period;
    logic [WIDTH_DIR-1:0]  target;
    logic                  pending;

    logic [WIDTH_DIR-1:0]  sel_clamped;
    logic [WIDTH_DATA-1:0] rom_period;
    logic                  at_term;

    // Requests above the populated range fall back to the last valid entry.
    assign sel_clamped = (sel > MAX_DIR) ? MAX_DIR : sel;

    // A zero ROM word would stall the divider; treat it as the fastest rate.
    assign rom_period = (rom_data == '0) ? ONE_DATA : rom_data;

    // Last cycle of the current half-period; only meaningful while running.
    assign at_term = (period != '0) && (cnt == period - ONE_DATA);

    // Sequencer FSM and divider share one register block.
    // The boundary swap and the pending flag stay in lockstep this way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LAT;
            cnt         <= '0;
            period      <= '0;
            next_period <= '0;
            target      <= '0;
            pending     <= 1'b0;
            rom_dir     <= '0;
            sel_ready   <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            cur_sel     <= '0;
            sel_done    <= 1'b0;
        end else begin
            tick     <= 1'b0;
            sel_done <= 1'b0;

            // Divider: the old half-period always completes before a swap.
            if (period != '0) begin
                if (at_term) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                    if (pending) begin
                        period   <= next_period;
                        cur_sel  <= target;
                        sel_done <= 1'b1;
                        pending  <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE_DATA;
                end
            end

            case (state)
                S_IDLE: begin
                    if (sel_valid && sel_ready) begin
                        rom_dir   <= sel_clamped;
                        target    <= sel_clamped;
                        sel_ready <= 1'b0;
                        state     <= S_LAT;
                    end
                end
                S_LAT: begin
                    // The ROM registers the word for rom_dir on this edge.
                    state <= S_CAP;
                end
                S_CAP: begin
                    next_period <= rom_period;
                    if (period == '0) begin
                        // Divider is stopped, so there is no boundary to wait for.
                        period    <= rom_period;
                        cnt       <= '0;
                        cur_sel   <= target;
                        sel_done  <= 1'b1;
                        sel_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        pending <= 1'b1;
                        state   <= S_PEND;
                    end
                end
                S_PEND: begin
                    // The divider performs the swap on this same terminal edge.
                    if (at_term) begin
                        sel_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
